// File: rtl/spi_slave_xcvr.sv
// 16-bit SPI slave (CPOL=0, CPHA=0) with oversampled pins,
// valid/ack receive port and one-entry load/ready transmit buffer.
module spi_slave_xcvr #(
  parameter int                WIDTH       = 16,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]  IDLE_WORD   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_cs_l,
  input  logic             spi_sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             rx_overrun,
  output logic             busy,
  output logic [4:0]       bit_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                   cs_d, sclk_d;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   rise, fall, cs_fall, cs_rise;
  logic [SYNC_STAGES:0]   fill;
  logic                   armed;
  logic                   start, last;

  logic [WIDTH-1:0]       rx_shift, rx_next;
  logic [WIDTH-1:0]       tx_shift, tx_buf, tx_word;
  logic                   tx_full;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;

  assign start   = (state == IDLE) & cs_fall & armed;
  assign last    = bit_count == 5'(WIDTH - 1);
  assign rx_next = {rx_shift[WIDTH-2:0], mosi_s};
  assign tx_word = tx_full ? tx_buf : IDLE_WORD;
  assign tx_ready = ~tx_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_l};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  // after reset the chains hold stale values; only a cs_fall seen
  // after cs is genuinely high again may start a frame
  always_ff @(posedge clk) begin
    if (reset) begin
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      fill <= {fill[SYNC_STAGES-1:0], 1'b1};
      if (fill[SYNC_STAGES] && cs_s && cs_d)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (cs_rise) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_n = ACTIVE;
        ACTIVE:  if (rise && last) state_n = DONE;
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miso       <= 1'b0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      bit_count  <= '0;
      tx_shift   <= '0;
      tx_buf     <= '0;
      tx_full    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_ack)
        rx_valid <= 1'b0;

      if (tx_load && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end else if (start) begin
        tx_full <= 1'b0;
      end

      if (cs_rise) begin
        miso      <= 1'b0;
        bit_count <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            miso      <= 1'b0;
            bit_count <= '0;
            if (start) begin
              tx_shift <= tx_word;
              miso     <= tx_word[WIDTH-1];
              rx_shift <= '0;
            end
          end
          ACTIVE: begin
            if (rise) begin
              rx_shift  <= rx_next;
              bit_count <= bit_count + 5'd1;
              if (last) begin
                rx_data    <= rx_next;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_ack;
              end
            end else if (fall) begin
              tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
              miso     <= tx_shift[WIDTH-2];
            end
          end
          DONE:    ;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Directed bench for spi_slave_xcvr: bit-banged master frames,
// hand-computed expectations for rx/tx handshakes, aborts and reset.
module tb_spi_slave_xcvr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs_l = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] tx_data = '0;
  logic        tx_load = 1'b0;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ack = 1'b0;
  logic        rx_overrun;
  logic        busy;
  logic [4:0]  bit_count;

  int checks = 0;
  int fails  = 0;

  logic [15:0] mi;
  logic        txr_cs;
  logic [4:1]  rv, ov;
  logic [4:0]  bc3;
  logic        busy3;

  spi_slave_xcvr dut (
    .clk        (clk),
    .reset      (reset),
    .spi_cs_l   (spi_cs_l),
    .spi_sclk   (spi_sclk),
    .mosi       (mosi),
    .miso       (miso),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .busy       (busy),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] d);
    tx_data = d;
    tx_load = 1'b1;
    nclk(1);
    tx_load = 1'b0;
  endtask

  task automatic ack;
    rx_ack = 1'b1;
    nclk(1);
    rx_ack = 1'b0;
  endtask

  // master frame, 4 clk per sclk phase; miso captured before each rise
  task automatic frame(input logic [15:0] mo, input int nbits,
                       input bit raise, input bit ack_done);
    mi = '0;
    spi_cs_l = 1'b0;
    nclk(4);
    txr_cs = tx_ready;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[15-i];
      nclk(4);
      mi = {mi[14:0], miso};
      spi_sclk = 1'b1;
      if (i == nbits - 1) begin
        for (int k = 1; k <= 4; k++) begin
          nclk(1);
          rv[k] = rx_valid;
          ov[k] = rx_overrun;
          if (k == 3) begin
            bc3    = bit_count;
            busy3  = busy;
            rx_ack = 1'b0;
          end
          if (k == 2 && ack_done) rx_ack = 1'b1;
        end
      end else begin
        nclk(4);
      end
      spi_sclk = 1'b0;
    end
    nclk(4);
    if (raise) begin
      spi_cs_l = 1'b1;
      nclk(4);
    end
  endtask

  initial begin
    nclk(3);
    reset = 1'b0;
    chk("rst_miso", 32'(miso), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bit_count", 32'(bit_count), 0);
    nclk(6);

    load(16'hA5C3);
    chk("t1_tx_ready_lo", 32'(tx_ready), 0);
    frame(16'h3C5A, 16, 1'b1, 1'b0);
    chk("t1_miso_word", 32'(mi), 'hA5C3);
    chk("t1_tx_ready_csfall", 32'(txr_cs), 1);
    chk("t1_valid_2clk", 32'(rv[2]), 0);
    chk("t1_valid_3clk", 32'(rv[3]), 1);
    chk("t1_done_count", 32'(bc3), 16);
    chk("t1_done_busy", 32'(busy3), 0);
    chk("t1_rx_data", 32'(rx_data), 'h3C5A);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_count_end", 32'(bit_count), 0);
    ack();
    chk("t1_ack_clear", 32'(rx_valid), 0);

    frame(16'hFFFF, 16, 1'b1, 1'b0);
    chk("t2_miso_idle", 32'(mi), 0);
    chk("t2_rx_data", 32'(rx_data), 'hFFFF);
    chk("t2_no_ovr", 32'(ov[3]), 0);
    chk("t2_valid", 32'(rx_valid), 1);
    ack();
    chk("t2_ack_clear", 32'(rx_valid), 0);
    ack();
    chk("t2_ack_idle", 32'(rx_valid), 0);

    frame(16'h1234, 16, 1'b1, 1'b0);
    chk("t3_first", 32'(rx_data), 'h1234);
    frame(16'h5678, 16, 1'b1, 1'b0);
    chk("t3_ovr_pulse", 32'(ov[3]), 1);
    chk("t3_ovr_single", 32'(ov[4]), 0);
    chk("t3_rx_data", 32'(rx_data), 'h5678);
    chk("t3_valid", 32'(rx_valid), 1);
    frame(16'h9ABC, 16, 1'b1, 1'b1);
    chk("t3_ack_no_ovr", 32'(ov[3]), 0);
    chk("t3_ack_valid", 32'(rv[3]), 1);
    chk("t3_ack_data", 32'(rx_data), 'h9ABC);
    chk("t3_ack_valid_end", 32'(rx_valid), 1);
    ack();

    frame(16'hFFFF, 9, 1'b1, 1'b0);
    chk("t4_mid_count", 32'(bc3), 9);
    chk("t4_mid_busy", 32'(busy3), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_count", 32'(bit_count), 0);
    chk("t4_valid", 32'(rx_valid), 0);
    chk("t4_data_kept", 32'(rx_data), 'h9ABC);
    frame(16'h00F0, 16, 1'b1, 1'b0);
    chk("t4_next_frame", 32'(rx_data), 'h00F0);
    chk("t4_next_valid", 32'(rx_valid), 1);
    ack();

    load(16'h1111);
    chk("t5_ready_lo", 32'(tx_ready), 0);
    load(16'h2222);
    frame(16'h0000, 16, 1'b1, 1'b0);
    chk("t5_sent", 32'(mi), 'h1111);
    chk("t5_ready_hi", 32'(tx_ready), 1);
    frame(16'h0000, 16, 1'b1, 1'b0);
    chk("t5_lost", 32'(mi), 0);

    frame(16'hBEEF, 7, 1'b0, 1'b0);
    reset = 1'b1;
    nclk(1);
    reset = 1'b0;
    chk("t6_rst_miso", 32'(miso), 0);
    chk("t6_rst_valid", 32'(rx_valid), 0);
    chk("t6_rst_data", 32'(rx_data), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_count", 32'(bit_count), 0);
    chk("t6_rst_ready", 32'(tx_ready), 1);
    for (int i = 0; i < 9; i++) begin
      spi_sclk = 1'b1;
      nclk(4);
      spi_sclk = 1'b0;
      nclk(4);
    end
    chk("t6_ign_busy", 32'(busy), 0);
    chk("t6_ign_count", 32'(bit_count), 0);
    spi_cs_l = 1'b1;
    nclk(4);
    chk("t6_ign_valid", 32'(rx_valid), 0);
    nclk(4);
    frame(16'hBEEF, 16, 1'b1, 1'b0);
    chk("t6_rx_data", 32'(rx_data), 'hBEEF);
    chk("t6_valid", 32'(rv[3]), 1);
    chk("t6_miso_idle", 32'(mi), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_xcvr.md
Name: spi_slave_xcvr

Overview:
16-bit SPI slave transceiver, the downstream counterpart of the team's SPI master. Consumes the master's spi_cs_l/spi_sclk/mosi and returns miso. spi_cs_l, spi_sclk and mosi are oversampled in the system clk domain. Received words go to a valid/ack output port; words to transmit come from a one-entry load/ready buffer.

Parameters:
WIDTH, 16, frame length in bits (MSB first).
SYNC_STAGES, 2, synchronizer flops per SPI input (>=2).
IDLE_WORD, 16'h0000, word shifted out when no tx word is buffered at frame start.

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
spi_cs_l  input  1  chip select, active low, asynchronous to clk
spi_sclk  input  1  SPI clock, CPOL=0, CPHA=0, asynchronous to clk
mosi  input  1  serial data from master
miso  output  1  serial data to master
tx_data  input  WIDTH  word to send in the next frame
tx_load  input  1  write strobe for tx_data
tx_ready  output  1  tx buffer empty; tx_load accepted only when high
rx_data  output  WIDTH  last complete received word
rx_valid  output  1  rx_data holds an unacknowledged word
rx_ack  input  1  consumer acknowledge; clears rx_valid
rx_overrun  output  1  one-cycle pulse: unacknowledged word overwritten
busy  output  1  frame in progress (state ACTIVE)
bit_count  output  5  bits received in the current frame, 0..WIDTH

Behaviour:
- Reset (sync, active-high): sync chains set to cs=1, sclk=0, mosi=0. State IDLE. miso=0, tx_ready=1, rx_data=0, rx_valid=0, rx_overrun=0, busy=0, bit_count=0. Shift registers and tx buffer cleared.
- Each SPI input passes through SYNC_STAGES flops (_s), plus one delay flop (_d).
- rise = sclk_s & ~sclk_d. fall = ~sclk_s & sclk_d. cs_fall = ~cs_s & cs_d. cs_rise = cs_s & ~cs_d.
- An action happens on the clk edge SYNC_STAGES cycles after the edge that first samples the pin change.
- Legal external timing:
  - Each sclk level held >= 2 clk cycles.
  - cs_l low >= 2 clk cycles before the first sclk rise.
  - mosi stable >= 1 clk cycle on both sides of each sclk rise.
- States:
  - IDLE: miso=0, bit_count=0. On cs_fall, go to ACTIVE:
    - If the tx buffer is full, tx_shift <= buffer, buffer emptied, tx_ready=1 next cycle. Otherwise tx_shift <= IDLE_WORD.
    - miso <= MSB of the loaded word. bit_count <= 0.
  - ACTIVE:
    - On rise: rx_shift <= {rx_shift[WIDTH-2:0], mosi_s}; bit_count++.
    - On fall: tx_shift <<= 1; miso <= the new MSB.
    - When a rise makes bit_count == WIDTH, go to DONE on the same edge: rx_data <= completed word, rx_valid <= 1.
    - On cs_rise before WIDTH bits: abort. Return to IDLE; rx_data and rx_valid unchanged; partial word discarded.
  - DONE: further sclk edges ignored; miso held. On cs_rise, go to IDLE.
- cs_rise in any state forces IDLE next edge. Same-edge sclk rise and cs_rise: cs_rise wins and the bit is not counted.
- rx handshake:
  - rx_valid stays high until a cycle with rx_ack=1, then clears on the next edge.
  - rx_ack while rx_valid=0 has no effect.
  - A new word completes while rx_valid=1 and rx_ack=0: rx_data is overwritten, rx_valid stays 1, rx_overrun=1 for one cycle.
  - A new word completes on the same cycle as rx_ack: rx_data gets the new word, rx_valid stays 1, no overrun.
- tx handshake:
  - tx_load && tx_ready: buffer <= tx_data; tx_ready <= 0 next edge.
  - tx_load while tx_ready=0: ignored, buffer unchanged.
  - tx_load on the same edge as a cs_fall that finds the buffer empty: the current frame sends IDLE_WORD; the loaded word waits for the next frame.
- busy = 1 exactly in ACTIVE. bit_count is held in DONE and zeroed in IDLE.
- Reset mid-frame: immediate return to reset values. A frame already in progress on the pins is ignored until a fresh cs_fall.

Test Plan:
1. Reset, then tx_load tx_data=16'hA5C3. Master frame, sclk 4 clk/phase, mosi=16'h3C5A -> miso bits 1010_0101_1100_0011 captured on rises. rx_valid=1, rx_data=16'h3C5A, SYNC_STAGES clk after the 16th rise; tx_ready=1 after cs_fall.
2. Empty tx buffer, frame mosi=16'hFFFF -> miso all 0 (IDLE_WORD), rx_data=16'hFFFF; then rx_ack -> rx_valid=0 next cycle.
3. Two frames 16'h1234 then 16'h5678, no rx_ack -> rx_overrun single-cycle pulse at the second completion, rx_data=16'h5678, rx_valid=1. Repeat with rx_ack on the completion cycle -> no overrun.
4. cs_l raised after 9 bits -> busy=0, bit_count=0, rx_valid unchanged. The next full frame 16'h00F0 is received correctly.
5. tx_load 16'h1111, then tx_load 16'h2222 while tx_ready=0 -> the next frame sends 16'h1111; 16'h2222 is lost.
6. reset asserted after 7 bits of a frame -> all outputs at reset values next cycle. Remaining sclk edges with cs_l still low are ignored. A later complete frame 16'hBEEF is received normally.
